// File: rtl/mult_pkg.sv
// Shared definitions for the serial multiplier host sequencer:
// default widths, watchdog limit and the sequencer state encoding.
package mult_pkg;

  localparam int W_DEF       = 12;
  localparam int TIMEOUT_DEF = 255;

  // Product of two W-bit signed operands needs 2W bits.
  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

  localparam int PROD_W_DEF = prod_width(W_DEF);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_F,
    ST_MUL,
    ST_WAIT_DONE,
    ST_UNLOAD,
    ST_RESULT,
    ST_ABORT
  } state_t;

endpackage

// File: rtl/mult_sequencer_if.sv
// Host and serial-multiplier signals of the sequencer.
// The sequencer connects to the slave modport; the host/multiplier side
// uses the master modport.
interface mult_sequencer_if
  import mult_pkg::*;
#(
  parameter int W = W_DEF
);

  logic                       start;
  logic [W-1:0]               x_op;
  logic [W-1:0]               y_op;
  logic                       busy;
  logic                       res_valid;
  logic [prod_width(W)-1:0]   result;
  logic                       err;
  logic                       x_ser;
  logic                       y_ser;
  logic                       sx;
  logic                       sy;
  logic                       fx;
  logic                       fy;
  logic                       mul;
  logic                       done;
  logic                       sz;
  logic                       z_ser;
  logic                       fz;

  modport slave (
    input  start, x_op, y_op, fx, fy, done, z_ser, fz,
    output busy, res_valid, result, err, x_ser, y_ser, sx, sy, mul, sz
  );

  modport master (
    output start, x_op, y_op, fx, fy, done, z_ser, fz,
    input  busy, res_valid, result, err, x_ser, y_ser, sx, sy, mul, sz
  );

endinterface

// File: rtl/piso_shifter.sv
// Parallel-in serial-out shifter, MSB first. Load has priority over
// shift; zeros enter from the LSB side so the register drains to zero.
module piso_shifter
  import mult_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] sr_q;
  logic [W-1:0] sr_d;

  // Next shift-register contents: capture, shift left, or hold.
  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = din;
    end else if (shift) begin
      sr_d = {sr_q[W-2:0], 1'b0};
    end
  end

  // Shift-register storage with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb = sr_q[W-1];

endmodule

// File: rtl/mult_sequencer.sv
// Host-side controller for the serial signed multiplier: shifts the
// operand pair in, issues the multiply, collects the product serially and
// presents it in parallel. A watchdog aborts stalled wait states.
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic             clk,
  input logic             rst,
  mult_sequencer_if.slave bus
);

  localparam int PW    = prod_width(W);
  localparam int CNT_W = $clog2(PW);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              fx_seen_q, fx_seen_d;
  logic              fy_seen_q, fy_seen_d;
  logic [PW-2:0]     zs_q, zs_d;
  logic [PW-1:0]     result_q, result_d;
  logic              busy_q, busy_d;
  logic              shift_xy_q, shift_xy_d;
  logic              mul_q, mul_d;
  logic              sz_q, sz_d;
  logic              res_valid_q, res_valid_d;
  logic              err_q, err_d;
  logic              load_ops;
  logic              shift_ops;
  logic              x_msb;
  logic              y_msb;

  assign load_ops  = (state_q == ST_IDLE) && bus.start;
  assign shift_ops = (state_q == ST_LOAD);

  piso_shifter #(.W(W)) u_x_shift (
    .clk   (clk),
    .rst   (rst),
    .load  (load_ops),
    .shift (shift_ops),
    .din   (bus.x_op),
    .msb   (x_msb)
  );

  piso_shifter #(.W(W)) u_y_shift (
    .clk   (clk),
    .rst   (rst),
    .load  (load_ops),
    .shift (shift_ops),
    .din   (bus.y_op),
    .msb   (y_msb)
  );

  // Sequencer next state, bit counter, watchdog, sticky full flags and
  // product collector. The collector keeps only the first 2W-1 bits; the
  // last bit is joined straight from z_ser when the product is committed.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    wd_d      = wd_q;
    fx_seen_d = fx_seen_q;
    fy_seen_d = fy_seen_q;
    zs_d      = zs_q;
    result_d  = result_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_LOAD;
          bit_cnt_d = '0;
        end
      end
      ST_LOAD: begin
        if (bit_cnt_q == CNT_W'(W - 1)) begin
          state_d   = ST_WAIT_F;
          wd_d      = '0;
          fx_seen_d = 1'b0;
          fy_seen_d = 1'b0;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_F: begin
        fx_seen_d = fx_seen_q | bus.fx;
        fy_seen_d = fy_seen_q | bus.fy;
        if (fx_seen_d && fy_seen_d) begin
          state_d = ST_MUL;
        end else if (wd_q == WD_W'(TIMEOUT)) begin
          state_d = ST_ABORT;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      ST_MUL: begin
        state_d = ST_WAIT_DONE;
        wd_d    = '0;
      end
      ST_WAIT_DONE: begin
        if (bus.done) begin
          state_d   = ST_UNLOAD;
          bit_cnt_d = '0;
        end else if (wd_q == WD_W'(TIMEOUT)) begin
          state_d = ST_ABORT;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      ST_UNLOAD: begin
        zs_d = {zs_q[PW-3:0], bus.z_ser};
        if (bit_cnt_q == CNT_W'(PW - 1)) begin
          if (bus.fz) begin
            state_d  = ST_RESULT;
            result_d = {zs_q, bus.z_ser};
          end else begin
            state_d = ST_ABORT;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      ST_RESULT: begin
        state_d = ST_IDLE;
      end
      ST_ABORT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the next state so the registered strobes
  // line up with the state they belong to.
  always_comb begin
    busy_d      = (state_d != ST_IDLE);
    shift_xy_d  = (state_d == ST_LOAD);
    mul_d       = (state_d == ST_MUL);
    sz_d        = (state_d == ST_UNLOAD);
    res_valid_d = (state_d == ST_RESULT);
    err_d       = (state_d == ST_ABORT);
  end

  // State, counters, collector and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      wd_q        <= '0;
      fx_seen_q   <= 1'b0;
      fy_seen_q   <= 1'b0;
      zs_q        <= '0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      shift_xy_q  <= 1'b0;
      mul_q       <= 1'b0;
      sz_q        <= 1'b0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      wd_q        <= wd_d;
      fx_seen_q   <= fx_seen_d;
      fy_seen_q   <= fy_seen_d;
      zs_q        <= zs_d;
      result_q    <= result_d;
      busy_q      <= busy_d;
      shift_xy_q  <= shift_xy_d;
      mul_q       <= mul_d;
      sz_q        <= sz_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.res_valid = res_valid_q;
  assign bus.result    = result_q;
  assign bus.err       = err_q;
  assign bus.x_ser     = x_msb;
  assign bus.y_ser     = y_msb;
  assign bus.sx        = shift_xy_q;
  assign bus.sy        = shift_xy_q;
  assign bus.mul       = mul_q;
  assign bus.sz        = sz_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer with a behavioural serial multiplier.
module tb_mult_sequencer;
  import mult_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mult_sequencer_if #(.W(W_DEF)) bus ();

  mult_sequencer #(.W(W_DEF), .TIMEOUT(TIMEOUT_DEF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Multiplier model knobs
  int fy_extra = 0;
  bit done_en  = 1'b1;
  bit drop_fz  = 1'b0;

  logic [11:0]               m_x, m_y;
  int                        m_xc, m_yc, m_fy_wait, m_zk;
  logic signed [PROD_W_DEF-1:0] m_prod;
  logic                      m_done;

  // Serial multiplier model: shift-in, multiply on request, shift-out
  always @(posedge clk) begin
    if (rst) begin
      m_x <= '0; m_y <= '0; m_xc <= 0; m_yc <= 0; m_fy_wait <= 0;
      m_zk <= 0; m_prod <= '0; m_done <= 1'b0;
    end else begin
      if (bus.sx) begin m_x <= {m_x[10:0], bus.x_ser}; m_xc <= m_xc + 1; end
      if (bus.sy) begin m_y <= {m_y[10:0], bus.y_ser}; m_yc <= m_yc + 1; end
      if (m_yc == 12 && m_fy_wait < fy_extra) m_fy_wait <= m_fy_wait + 1;
      if (bus.mul) begin
        m_prod <= $signed(m_x) * $signed(m_y);
        m_done <= done_en;
        m_xc <= 0; m_yc <= 0; m_fy_wait <= 0; m_zk <= 0;
      end
      if (bus.sz) begin m_zk <= m_zk + 1; m_done <= 1'b0; end
    end
  end

  assign bus.fx    = (m_xc == 12);
  assign bus.fy    = (m_yc == 12) && (m_fy_wait >= fy_extra);
  assign bus.done  = m_done;
  assign bus.z_ser = (m_zk < PROD_W_DEF) ? m_prod[PROD_W_DEF - 1 - m_zk] : 1'b0;
  assign bus.fz    = (m_zk == PROD_W_DEF - 1) && !drop_fz;

  int errors = 0;
  int checks = 0;

  int          op_cycle, sx_cnt, sy_cnt, mul_cnt, mul_n, fy_n, extra_valid, extra_busy;
  bit          got_valid, got_err;
  logic [11:0] xstream, ystream;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] x, input logic [11:0] y);
    bus.x_op  = x;
    bus.y_op  = y;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Cycle numbering: the cycle in which start is accepted is cycle 1, so
  // sample n (taken n edges after the accepting edge) is cycle n+1.
  task automatic runOp(input int first_n, input int limit);
    op_cycle = 0; got_valid = 0; got_err = 0;
    sx_cnt = 0; sy_cnt = 0; mul_cnt = 0; mul_n = 0; fy_n = 0;
    xstream = '0; ystream = '0;
    for (int n = first_n; n <= limit; n++) begin
      if (bus.sx) begin xstream = {xstream[10:0], bus.x_ser}; sx_cnt++; end
      if (bus.sy) begin ystream = {ystream[10:0], bus.y_ser}; sy_cnt++; end
      if (bus.fy && fy_n == 0) fy_n = n;
      if (bus.mul) begin mul_cnt++; mul_n = n; end
      if (bus.res_valid || bus.err) begin
        op_cycle  = n + 1;
        got_valid = bus.res_valid;
        got_err   = bus.err;
        tick();
        break;
      end
      tick();
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] stopped");
  end

  initial begin
    bus.start = 1'b0;
    bus.x_op  = '0;
    bus.y_op  = '0;
    rst = 1'b1;
    repeat (3) tick();
    checkOutput("reset_busy",      bus.busy,      32'd0);
    checkOutput("reset_res_valid", bus.res_valid, 32'd0);
    checkOutput("reset_err",       bus.err,       32'd0);
    checkOutput("reset_sx",        bus.sx,        32'd0);
    checkOutput("reset_mul",       bus.mul,       32'd0);
    checkOutput("reset_sz",        bus.sz,        32'd0);
    checkOutput("reset_x_ser",     bus.x_ser,     32'd0);
    checkOutput("reset_result",    bus.result,    32'd0);
    rst = 1'b0;
    tick();

    // 5 * -3 = -15, best-case latency
    applyStimulus(12'd5, 12'hFFD);
    checkOutput("op1_busy_rise", bus.busy, 32'd1);
    runOp(1, 400);
    checkOutput("op1_x_stream",  xstream,   32'h005);
    checkOutput("op1_y_stream",  ystream,   32'hFFD);
    checkOutput("op1_sx_cycles", sx_cnt,    32'd12);
    checkOutput("op1_sy_cycles", sy_cnt,    32'd12);
    checkOutput("op1_mul_count", mul_cnt,   32'd1);
    checkOutput("op1_valid",     got_valid, 32'd1);
    checkOutput("op1_cycle",     op_cycle,  32'd41);
    checkOutput("op1_result",    bus.result, 32'h00FFFFF1);
    checkOutput("op1_busy_fall", bus.busy,  32'd0);

    // 2047 * 0 back-to-back, fy seven cycles behind fx
    fy_extra = 7;
    applyStimulus(12'd2047, 12'd0);
    runOp(1, 400);
    fy_extra = 0;
    checkOutput("fy_first_high", fy_n,      32'd20);
    checkOutput("fy_mul_cycle",  mul_n,     32'd21);
    checkOutput("fy_mul_count",  mul_cnt,   32'd1);
    checkOutput("fy_valid",      got_valid, 32'd1);
    checkOutput("fy_cycle",      op_cycle,  32'd48);
    checkOutput("fy_result",     bus.result, 32'h00000000);

    // -2048 * -2048 = 0x400000
    applyStimulus(12'h800, 12'h800);
    runOp(1, 400);
    checkOutput("neg_valid",  got_valid, 32'd1);
    checkOutput("neg_cycle",  op_cycle,  32'd41);
    checkOutput("neg_result", bus.result, 32'h00400000);

    // done never arrives: watchdog abort after 256 WAIT_DONE cycles
    done_en = 1'b0;
    applyStimulus(12'd1, 12'd1);
    runOp(1, 600);
    done_en = 1'b1;
    checkOutput("wd_err",       got_err,   32'd1);
    checkOutput("wd_no_valid",  got_valid, 32'd0);
    checkOutput("wd_cycle",     op_cycle,  32'd272);
    checkOutput("wd_busy_fall", bus.busy,  32'd0);
    checkOutput("wd_result",    bus.result, 32'h00400000);

    // fz missing on the final product bit
    drop_fz = 1'b1;
    applyStimulus(12'd3, 12'd5);
    runOp(1, 400);
    drop_fz = 1'b0;
    checkOutput("fz_err",      got_err,   32'd1);
    checkOutput("fz_no_valid", got_valid, 32'd0);
    checkOutput("fz_cycle",    op_cycle,  32'd41);
    checkOutput("fz_result",   bus.result, 32'h00400000);

    // reset during UNLOAD bit 10
    applyStimulus(12'd3, 12'd3);
    repeat (25) tick();
    checkOutput("rst_in_unload", bus.sz, 32'd1);
    rst = 1'b1;
    tick();
    checkOutput("rst_busy",      bus.busy,      32'd0);
    checkOutput("rst_sz",        bus.sz,        32'd0);
    checkOutput("rst_err",       bus.err,       32'd0);
    checkOutput("rst_res_valid", bus.res_valid, 32'd0);
    checkOutput("rst_sx",        bus.sx,        32'd0);
    checkOutput("rst_mul",       bus.mul,       32'd0);
    checkOutput("rst_y_ser",     bus.y_ser,     32'd0);
    checkOutput("rst_result",    bus.result,    32'd0);
    rst = 1'b0;
    tick();

    // start held during LOAD with other operands must be ignored
    applyStimulus(12'd5, 12'hFFD);
    bus.start = 1'b1;
    bus.x_op  = 12'd7;
    bus.y_op  = 12'd7;
    tick();
    tick();
    bus.start = 1'b0;
    runOp(3, 400);
    checkOutput("ign_valid",  got_valid, 32'd1);
    checkOutput("ign_cycle",  op_cycle,  32'd41);
    checkOutput("ign_result", bus.result, 32'h00FFFFF1);
    extra_valid = 0;
    extra_busy  = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.res_valid) extra_valid++;
      if (bus.busy) extra_busy++;
      tick();
    end
    checkOutput("ign_extra_valid", extra_valid, 32'd0);
    checkOutput("ign_extra_busy",  extra_busy,  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Host-side controller sitting directly upstream and downstream of the serial signed 12x12 multiplier. It accepts a parallel operand pair on a start strobe and shifts both operands MSB-first into the multiplier. It then issues the multiply, waits for completion, shifts the 24-bit signed product back out, and presents it in parallel with a valid strobe. A watchdog aborts any phase that stalls.

## Interface
Parameters:
- `W`, 12, operand width.
- `TIMEOUT`, 255, maximum cycles spent in any wait state before abort.

Ports:
- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  host request; sampled only in IDLE.
- `x_op`  in  W  signed operand x, captured on accepted `start`.
- `y_op`  in  W  signed operand y, captured on accepted `start`.
- `busy`  out  1  high from accepted `start` until the RESULT or ABORT cycle completes.
- `res_valid`  out  1  one-cycle pulse; `result` valid.
- `result`  out  2W  signed product; held until next accepted `start`.
- `err`  out  1  one-cycle pulse on watchdog abort.
- `x_ser`, `y_ser`  out  1  serial operand bits to multiplier.
- `sx`, `sy`  out  1  shift enables; bit presented on `x_ser`/`y_ser` is shifted in on each edge with enable high.
- `fx`, `fy`  in  1  multiplier reports its input register full.
- `mul`  out  1  one-cycle multiply request.
- `done`  in  1  multiplier product ready (level).
- `sz`  out  1  output shift enable.
- `z_ser`  in  1  serial product bit, MSB-first; bit 2W-1-k during k-th cycle `sz` high.
- `fz`  in  1  high while bit 0 is presented.

## Operation
- States: IDLE, LOAD, WAIT_F, MUL, WAIT_DONE, UNLOAD, RESULT, ABORT.
- IDLE: `start`=1 → latch operands into shift registers `xs`/`ys`, clear bit counter, go LOAD.
- LOAD: `sx`=`sy`=1 for exactly W cycles; `x_ser`=`xs[W-1]`, `y_ser`=`ys[W-1]`, then shift left each cycle. When counter reaches W-1, go WAIT_F.
- WAIT_F: wait for `fx`&`fy` both high (they need not rise on the same cycle; each is latched sticky) → MUL.
- MUL: `mul`=1 for one cycle → WAIT_DONE.
- WAIT_DONE: `done`=1 → UNLOAD with counter cleared.
- UNLOAD: `sz`=1 for exactly 2W cycles; shift `z_ser` into the LSB of collector `zs` each cycle. On the 2W-th cycle, `fz` must be 1. If it is not, go ABORT. Otherwise go RESULT.
- RESULT: `result`←`zs`, `res_valid`=1 for one cycle → IDLE.
- ABORT: `err`=1 for one cycle; `result` unchanged → IDLE.
- Watchdog: counter cleared on entry to WAIT_F and WAIT_DONE. It increments while waiting; when it reaches TIMEOUT, go ABORT. LOAD and UNLOAD are fixed-length and are not watched.
- Outputs are registered (Moore). `start` outside IDLE is ignored, with no queueing.
- `done` already high on entry to WAIT_DONE is accepted immediately.
- `fz` asserted early during UNLOAD is ignored; only the 2W-th cycle is checked.

## Timing
- Reset values: state IDLE; `busy`, `res_valid`, `err`, `sx`, `sy`, `mul`, `sz`, `x_ser`, `y_ser` = 0; `result` = 0; all counters and sticky flags = 0.
- `rst` mid-operation returns to IDLE on the next edge with no `err` pulse. The multiplier is reset by the same `rst`.
- `busy` rises the cycle after `start` is accepted and falls in the cycle after RESULT/ABORT.
- Best-case latency, `start` to `res_valid`, with `fx`/`fy` immediate and `done` one cycle after `mul`: 1 + W + 1 + 1 + 1 + 2W + 1 = 3W+5 = 41 cycles for W=12.
- Back-to-back: a new `start` is accepted in the first IDLE cycle after `res_valid`.

## Structure
- Shared package `mult_pkg`: W default, state enum, TIMEOUT default, product width 2W.
- One sub-module is natural: `piso_shifter` (parallel-in serial-out, MSB-first, with load and shift enables), instantiated twice for x and y. The collector is inline.
- The FSM, watchdog and bit counter are in the top level.

## Test plan
- x=5, y=-3 (0xFFD), bench multiplier model → `x_ser` stream 000000000101 MSB-first with `sx` high 12 cycles; `result`=-15 (0xFFFFF1), `res_valid` at cycle 41.
- x=-2048, y=-2048 → `result`=0x400000; x=2047, y=0 → `result`=0.
- `fx` at cycle +0 of WAIT_F, `fy` 7 cycles later → MUL entered the cycle after `fy`; exactly one `mul` pulse.
- `done` never asserted, TIMEOUT=255 → `err` pulse 256 cycles into WAIT_DONE; `busy` falls; `result` retains previous value.
- Model drops `fz` on the final UNLOAD bit → `err`, no `res_valid`.
- `rst` asserted during UNLOAD bit 10 → next cycle IDLE, all outputs at reset values. `start` during LOAD is ignored: exactly one `res_valid` per accepted `start`.
